// File: rtl/bitcnt_pkg.sv
// Shared types and constants for the Zbb bit-count execute stage.
package bitcnt_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 6;

    typedef enum logic [1:0] {
        OP_CPOP = 2'b00,
        OP_CLZ  = 2'b01,
        OP_CTZ  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        WB   = 2'b10
    } state_e;

endpackage

// File: rtl/bitcnt_if.sv
// Request handshake and register-file write bundle for bitcnt_unit.
interface bitcnt_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned AW   = 5
);
    logic            start_valid;
    logic            start_ready;
    logic [1:0]      op;
    logic [XLEN-1:0] rs1_val;
    logic [AW-1:0]   rd;
    logic            kill;
    logic            busy;
    logic            done;
    logic            rf_we;
    logic [AW-1:0]   rf_wa;
    logic [XLEN-1:0] rf_wd;

    modport master (
        output start_valid, op, rs1_val, rd, kill,
        input  start_ready, busy, done, rf_we, rf_wa, rf_wd
    );

    modport slave (
        input  start_valid, op, rs1_val, rd, kill,
        output start_ready, busy, done, rf_we, rf_wa, rf_wd
    );
endinterface

// File: rtl/bitcnt_chunk.sv
// Combinational popcount / leading-zero / trailing-zero of one W-bit chunk.
module bitcnt_chunk #(
    parameter  int unsigned W  = 4,
    localparam int unsigned CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  din,
    output logic [CW-1:0] pop,
    output logic [CW-1:0] lz,
    output logic [CW-1:0] tz,
    output logic          nz
);
    always_comb begin
        pop = '0;
        lz  = CW'(W);
        tz  = CW'(W);
        // Ascending scan: the highest set bit is the last to update lz.
        for (int unsigned i = 0; i < W; i++) begin
            pop = pop + CW'(din[i]);
            if (din[i]) lz = CW'(W - 1 - i);
        end
        for (int unsigned i = W; i > 0; i--) begin
            if (din[i-1]) tz = CW'(i - 1);
        end
        nz = |din;
    end
endmodule

// File: rtl/bitcnt_unit.sv
// Iterative CPOP/CLZ/CTZ execute stage feeding the register file write port.
// Optional EARLY_EXIT_EN: leave BUSY as soon as the remaining work is zero.
module bitcnt_unit #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned BITS_PER_CYCLE = 4,
    parameter int unsigned AW             = 5
) (
    input logic     clk,
    input logic     rst_n,
    bitcnt_if.slave bus
);
    import bitcnt_pkg::*;

    localparam int unsigned NCHUNK = XLEN / BITS_PER_CYCLE;
    localparam int unsigned IDX_W  = $clog2(NCHUNK) + 1;
    localparam int unsigned CHW    = $clog2(BITS_PER_CYCLE + 1);

    state_e state, state_n;
    op_e                 op_q;
    logic [AW-1:0]       rd_q;
    logic [AW-1:0]       rf_wa_q;
    logic [XLEN-1:0]     shreg, shreg_n;
    logic [CNT_W-1:0]    count, count_n, cnt_add, rf_wd_q;
    logic                found, found_n;
    logic [IDX_W-1:0]    idx;
    logic                last, accept;
    logic [BITS_PER_CYCLE-1:0] chunk;
    logic [CHW-1:0]      c_pop, c_lz, c_tz;
    logic                c_nz;

    // CLZ walks from the MSB end, CPOP/CTZ from the LSB end.
    assign chunk = (op_q == OP_CLZ) ? shreg[XLEN-1 -: BITS_PER_CYCLE]
                                    : shreg[BITS_PER_CYCLE-1:0];

    bitcnt_chunk #(.W(BITS_PER_CYCLE)) u_chunk (
        .din (chunk),
        .pop (c_pop),
        .lz  (c_lz),
        .tz  (c_tz),
        .nz  (c_nz)
    );

    always_comb begin
        cnt_add = '0;
        found_n = found;
        case (op_q)
            OP_CPOP: cnt_add = CNT_W'(c_pop);
            OP_CLZ: begin
                if (!found) cnt_add = CNT_W'(c_lz);
                found_n = found | c_nz;
            end
            OP_CTZ: begin
                if (!found) cnt_add = CNT_W'(c_tz);
                found_n = found | c_nz;
            end
            default: cnt_add = '0;
        endcase
        count_n = count + cnt_add;
        shreg_n = (op_q == OP_CLZ) ? (shreg << BITS_PER_CYCLE) : (shreg >> BITS_PER_CYCLE);
        last    = (idx == IDX_W'(NCHUNK - 1));
`ifdef EARLY_EXIT_EN
        if ((op_q == OP_CPOP) && (shreg_n == '0)) last = 1'b1;
        if (((op_q == OP_CLZ) || (op_q == OP_CTZ)) && found_n) last = 1'b1;
`else
`endif
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start_valid && !bus.kill) begin
                    accept  = 1'b1;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (bus.kill)  state_n = IDLE;
                else if (last) state_n = WB;
            end
            WB:      state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q    <= OP_CPOP;
            rd_q    <= '0;
            shreg   <= '0;
            count   <= '0;
            found   <= 1'b0;
            idx     <= '0;
            rf_wa_q <= '0;
            rf_wd_q <= '0;
        end else if (accept) begin
            op_q  <= op_e'(bus.op);
            rd_q  <= bus.rd;
            shreg <= bus.rs1_val;
            count <= '0;
            found <= 1'b0;
            idx   <= '0;
        end else if ((state == BUSY) && !bus.kill) begin
            shreg <= shreg_n;
            count <= count_n;
            found <= found_n;
            idx   <= idx + IDX_W'(1);
            // Result registers are loaded only when WB is entered so they hold otherwise.
            if (last) begin
                rf_wa_q <= rd_q;
                rf_wd_q <= count_n;
            end
        end
    end

    assign bus.start_ready = (state == IDLE);
    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == WB);
    assign bus.rf_we       = (state == WB) && (rd_q != '0);
    assign bus.rf_wa       = rf_wa_q;
    assign bus.rf_wd       = XLEN'(rf_wd_q);
endmodule

// File: tb/tb_bitcnt_unit.sv
// Self-checking bench for bitcnt_unit: vector table, scoreboard and corner sequences.
module tb_bitcnt_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    bitcnt_if #(.XLEN(32), .AW(5)) bus ();

    bitcnt_unit #(.XLEN(32), .BITS_PER_CYCLE(4), .AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] v;
        logic [4:0]  rd;
        logic [31:0] wd;
    } vec_t;

    exp_t sbq[$];
    exp_t mon_e;
    vec_t tbl[14];
    vec_t qreq[3];
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_done  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] model_result(input logic [1:0] op, input logic [31:0] v);
        int n;
        n = 0;
        case (op)
            2'b00: for (int i = 0; i < 32; i++) if (v[i]) n++;
            2'b01: begin
                n = 32;
                for (int i = 31; i >= 0; i--) if (v[i]) begin n = 31 - i; break; end
            end
            2'b10: begin
                n = 32;
                for (int i = 0; i < 32; i++) if (v[i]) begin n = i; break; end
            end
            default: n = 0;
        endcase
        return 32'(n);
    endfunction

    // Number of BUSY cycles the request should occupy.
    function automatic int exp_busy(input logic [1:0] op, input logic [31:0] v);
        int n;
        n = 8;
`ifdef EARLY_EXIT_EN
        case (op)
            2'b00: begin
                n = 1;
                for (int i = 0; i < 8; i++) if (v[4*i +: 4] != 4'h0) n = i + 1;
            end
            2'b01: for (int i = 7; i >= 0; i--) if (v[4*i +: 4] != 4'h0) begin n = 8 - i; break; end
            2'b10: for (int i = 0; i < 8; i++) if (v[4*i +: 4] != 4'h0) begin n = i + 1; break; end
            default: n = 8;
        endcase
`else
        n = (op == 2'b11) ? 8 : 8;
`endif
        return n;
    endfunction

    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            n_done++;
            check("sb_nonempty", sbq.size() != 0, 1);
            if (sbq.size() != 0) begin
                mon_e = sbq.pop_front();
                check("rf_we", bus.rf_we, mon_e.we);
                check("rf_wa", bus.rf_wa, mon_e.wa);
                check("rf_wd", bus.rf_wd, mon_e.wd);
            end
        end
        if (bus.rf_we) check("we_only_in_wb", bus.done, 1);
    end

    task automatic push_exp(input logic [4:0] rd, input logic [31:0] wd);
        exp_t e;
        e.we = (rd != 5'd0);
        e.wa = rd;
        e.wd = wd;
        sbq.push_back(e);
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] v, input logic [4:0] rd,
                         input logic [31:0] wd);
        int g;
        int dc;
        g = 0;
        while (!bus.start_ready && g < 40) begin @(negedge clk); g++; end
        check("ready_before_issue", bus.start_ready, 1);
        bus.op = op; bus.rs1_val = v; bus.rd = rd; bus.start_valid = 1'b1;
        push_exp(rd, wd);
        @(posedge clk);
        @(negedge clk);
        bus.start_valid = 1'b0;
        check("busy_after_accept", bus.busy, 1);
        check("ready_low_in_busy", bus.start_ready, 0);
        dc = 0;
        for (int k = 1; k <= 30; k++) begin
            if (k > 1) @(negedge clk);
            if (bus.done) begin dc = k; break; end
        end
        check("done_cycle", dc, exp_busy(op, v) + 1);
        @(negedge clk);
        check("ready_after_wb", bus.start_ready, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, bus.start_ready, 1);
        check({tag, "_busy"},  bus.busy, 0);
        check({tag, "_done"},  bus.done, 0);
        check({tag, "_we"},    bus.rf_we, 0);
        check({tag, "_wa"},    bus.rf_wa, 0);
        check({tag, "_wd"},    bus.rf_wd, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no summary expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d0, idx, cyc, last_acc, g, prev_busy;
        bit acc;
        logic [1:0]  rop;
        logic [31:0] rv;
        logic [4:0]  rrd;

        tbl[0]  = '{2'b00, 32'hF0F0_F0F0, 5'd5,  32'd16};
        tbl[1]  = '{2'b01, 32'h0001_0000, 5'd7,  32'd15};
        tbl[2]  = '{2'b10, 32'h0001_0000, 5'd8,  32'd16};
        tbl[3]  = '{2'b01, 32'h0000_0000, 5'd9,  32'd32};
        tbl[4]  = '{2'b10, 32'h0000_0000, 5'd10, 32'd32};
        tbl[5]  = '{2'b00, 32'hFFFF_FFFF, 5'd11, 32'd32};
        tbl[6]  = '{2'b00, 32'h0000_0001, 5'd0,  32'd1};
        tbl[7]  = '{2'b11, 32'hDEAD_BEEF, 5'd3,  32'd0};
        tbl[8]  = '{2'b01, 32'h8000_0000, 5'd12, 32'd0};
        tbl[9]  = '{2'b10, 32'h8000_0000, 5'd13, 32'd31};
        tbl[10] = '{2'b01, 32'h0000_0001, 5'd14, 32'd31};
        tbl[11] = '{2'b10, 32'h0000_0001, 5'd15, 32'd0};
        tbl[12] = '{2'b00, 32'h1234_5678, 5'd31, 32'd13};
        tbl[13] = '{2'b01, 32'h00F0_0000, 5'd16, 32'd8};

        qreq[0] = '{2'b00, 32'hF0F0_F0F0, 5'd1, 32'd16};
        qreq[1] = '{2'b01, 32'h0000_1000, 5'd2, 32'd19};
        qreq[2] = '{2'b10, 32'h0000_1000, 5'd3, 32'd12};

        bus.start_valid = 1'b0; bus.op = 2'b00; bus.rs1_val = '0; bus.rd = '0; bus.kill = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) issue(tbl[i].op, tbl[i].v, tbl[i].rd, tbl[i].wd);

        for (int i = 0; i < 8; i++) begin
            rop = 2'($urandom_range(0, 3));
            rv  = $urandom;
            if (i[0]) rv = rv & 32'h00FF_0F00;
            rrd = 5'($urandom_range(0, 31));
            issue(rop, rv, rrd, model_result(rop, rv));
        end

        // kill while idle must block acceptance
        bus.op = 2'b00; bus.rs1_val = 32'h1; bus.rd = 5'd4;
        bus.start_valid = 1'b1; bus.kill = 1'b1;
        @(negedge clk);
        check("kill_idle_blocks", bus.busy, 0);
        bus.start_valid = 1'b0; bus.kill = 1'b0;

        // kill in BUSY cycle 4: no write, no done
        bus.op = 2'b00; bus.rs1_val = 32'hFFFF_FFFF; bus.rd = 5'd9; bus.start_valid = 1'b1;
        @(negedge clk);
        bus.start_valid = 1'b0;
        repeat (3) @(negedge clk);
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        check("kill_busy_idle", bus.busy, 0);
        check("kill_busy_ready", bus.start_ready, 1);
        d0 = n_done;
        repeat (12) @(negedge clk);
        check("kill_no_done", n_done - d0, 0);

        // kill during WB is ignored
        bus.op = 2'b00; bus.rs1_val = 32'h0000_00FF; bus.rd = 5'd17; bus.start_valid = 1'b1;
        push_exp(5'd17, 32'd8);
        @(negedge clk);
        bus.start_valid = 1'b0;
        g = 0;
        while (!bus.done && g < 30) begin @(negedge clk); g++; end
        check("kill_wb_reached", bus.done, 1);
        bus.kill = 1'b1;
        @(negedge clk);
        bus.kill = 1'b0;
        check("kill_wb_ready", bus.start_ready, 1);
        check("kill_wb_sb_empty", sbq.size(), 0);

        // reset in BUSY cycle 6
        bus.op = 2'b01; bus.rs1_val = 32'h0000_0001; bus.rd = 5'd12; bus.start_valid = 1'b1;
        @(negedge clk);
        bus.start_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        d0 = n_done;
        repeat (12) @(negedge clk);
        check("reset_no_done", n_done - d0, 0);
        issue(2'b10, 32'h0000_0100, 5'd4, 32'd8);

        // back-to-back requests with start_valid held high
        d0 = n_done; idx = 0; cyc = 0; last_acc = 0; prev_busy = 0;
        bus.op = qreq[0].op; bus.rs1_val = qreq[0].v; bus.rd = qreq[0].rd; bus.start_valid = 1'b1;
        while (idx < 3 && cyc < 200) begin
            acc = bus.start_ready && !bus.kill;
            if (acc) begin
                push_exp(qreq[idx].rd, qreq[idx].wd);
                if (idx > 0) check("accept_spacing", cyc - last_acc, prev_busy + 2);
                prev_busy = exp_busy(qreq[idx].op, qreq[idx].v);
                last_acc = cyc;
                idx++;
            end
            @(negedge clk);
            cyc++;
            if (acc) begin
                if (idx < 3) begin
                    bus.op = qreq[idx].op; bus.rs1_val = qreq[idx].v; bus.rd = qreq[idx].rd;
                end else begin
                    bus.start_valid = 1'b0;
                end
            end
        end
        check("queued_accepts", idx, 3);
        g = 0;
        while (sbq.size() != 0 && g < 40) begin @(negedge clk); g++; end
        check("queued_writes", n_done - d0, 3);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
